// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus falling-edge detect.
// All flops reset to 1 (PS/2 idle level) so no edge is reported after reset.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~dout;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: 11-bit frame sequencer with a one-entry valid/ready output.
// Optional prefix decoding (E0/F0 -> rx_ext/rx_break) is enabled by PS2_BREAK_DECODE_EN.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TMO_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef PS2_BREAK_DECODE_EN
    ,
    output logic       rx_break,
    output logic       rx_ext
`endif
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic clk_s, clk_fall, data_s;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clock (clock),
        .reset (reset),
        .din   (ps2_clk),
        .dout  (clk_s),
        .fall  (clk_fall)
    );

    // Data pin shares the clock pin's stage count, so sampling on fall stays aligned.
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    assign dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    assign data_s  = dsync_q[SYNC_STAGES-1];

    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             good_byte, deliver;
`ifdef PS2_BREAK_DECODE_EN
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             rx_ext_q, rx_ext_d;
    logic             rx_break_q, rx_break_d;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        good_byte    = 1'b0;
        deliver      = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // A falling edge always wins over the timeout and restarts the idle count.
        if (clk_fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (!parity_ok(shift_q, parity_q)) begin
                        parity_err_d = 1'b1;
                    end else begin
                        good_byte = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                shift_d     = '0;
                bit_cnt_d   = '0;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

`ifdef PS2_BREAK_DECODE_EN
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        rx_ext_d   = rx_ext_q;
        rx_break_d = rx_break_q;
        if (frame_err_d || parity_err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
        if (good_byte) begin
            if (shift_q == PS2_PREFIX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                deliver    = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
`else
        deliver = good_byte;
`endif

        // Load when empty or when the current byte is being drained this cycle.
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                rx_ext_d   = ext_pend_q;
                rx_break_d = brk_pend_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dsync_q      <= '1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            rx_ext_q     <= 1'b0;
            rx_break_q   <= 1'b0;
`endif
        end else begin
            dsync_q      <= dsync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef PS2_BREAK_DECODE_EN
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            rx_ext_q     <= rx_ext_d;
            rx_break_q   <= rx_break_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
`ifdef PS2_BREAK_DECODE_EN
    assign rx_ext     = rx_ext_q;
    assign rx_break   = rx_break_q;
`endif

    // The synchronised clock level itself is only needed for edge detection.
    logic unused_clk_s;
    assign unused_clk_s = clk_s;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed self-checking bench for ps2_rx_ctrl with a shortened timeout and fast PS/2 clock.
module tb_ps2_rx_ctrl;

    localparam int HALF    = 20;
    localparam int TMO     = 200;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef PS2_BREAK_DECODE_EN
    logic       rx_break;
    logic       rx_ext;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ps2_rx_ctrl #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef PS2_BREAK_DECODE_EN
        ,
        .rx_break   (rx_break),
        .rx_ext     (rx_ext)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives n bits (LSB of bits first); returns right after the last clock fall.
    task automatic drive_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            if (i < n - 1) begin
                wait_clks(HALF);
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        drive_bits({stop, (~^b) ^ flip, b, 1'b0}, 11);
    endtask

    // Two synchroniser flops plus the edge flop, then the registered result.
    task automatic wait_eval();
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic release_bus();
        wait_clks(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic drain();
        @(negedge clock);
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("drain_valid", rx_valid, 0);
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  seen;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rx_ready = 1'b0;
        wait_clks(5);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        wait_clks(5);
        chk("idle_busy", busy, 0);

        // Good 0x1C frame, exact latency
        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        chk("good_pre_valid", rx_valid, 0);
        chk("good_pre_busy", busy, 1);
        @(posedge clock);
        #1;
        chk("good_valid", rx_valid, 1);
        chk("good_data", rx_data, 8'h1C);
        chk("good_parity_err", parity_err, 0);
        chk("good_frame_err", frame_err, 0);
        chk("good_busy", busy, 0);
        release_bus();
        chk("good_hold_data", rx_data, 8'h1C);
        drain();

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1);
        wait_eval();
        chk("par_pulse", parity_err, 1);
        chk("par_frame_err", frame_err, 0);
        chk("par_valid", rx_valid, 0);
        @(posedge clock);
        #1;
        chk("par_pulse_end", parity_err, 0);
        chk("par_valid_after", rx_valid, 0);
        release_bus();

        // Bad stop bit, then recovery
        send_frame(8'h1C, 1'b0, 1'b0);
        wait_eval();
        chk("stop_frame_err", frame_err, 1);
        chk("stop_parity_err", parity_err, 0);
        chk("stop_busy", busy, 0);
        chk("stop_valid", rx_valid, 0);
        @(posedge clock);
        #1;
        chk("stop_pulse_end", frame_err, 0);
        release_bus();
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_eval();
        chk("recov_valid", rx_valid, 1);
        chk("recov_data", rx_data, 8'h1C);
        release_bus();
        drain();

        // Timeout after start + 4 data bits
        drive_bits({1'b1, 1'b0, 8'h32, 1'b0}, 5);
        wait_clks(HALF);
        ps2_clk = 1'b1;
        chk("tmo_busy_mid", busy, 1);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 3 * TMO; i++) begin
            @(posedge clock);
            #1;
            if (frame_err) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
        end
        chk("tmo_seen", seen, 1);
        chk("tmo_cycles", cyc, TMO + 3 - HALF);
        chk("tmo_busy", busy, 0);
        chk("tmo_valid", rx_valid, 0);
        @(posedge clock);
        #1;
        chk("tmo_pulse_end", frame_err, 0);
        wait_clks(2 * HALF);
        send_frame(8'h32, 1'b0, 1'b1);
        wait_eval();
        chk("tmo_next_valid", rx_valid, 1);
        chk("tmo_next_data", rx_data, 8'h32);
        release_bus();
        drain();

        // Overrun
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_eval();
        chk("ovr_first_valid", rx_valid, 1);
        release_bus();
        send_frame(8'h32, 1'b0, 1'b1);
        wait_eval();
        chk("ovr_pulse", overrun, 1);
        chk("ovr_data_kept", rx_data, 8'h1C);
        chk("ovr_valid", rx_valid, 1);
        @(posedge clock);
        #1;
        chk("ovr_pulse_end", overrun, 0);
        release_bus();
        chk("ovr_data_still", rx_data, 8'h1C);
        drain();

`ifdef PS2_BREAK_DECODE_EN
        send_frame(8'hE0, 1'b0, 1'b1);
        wait_eval();
        chk("brk_e0_valid", rx_valid, 0);
        release_bus();
        send_frame(8'hF0, 1'b0, 1'b1);
        wait_eval();
        chk("brk_f0_valid", rx_valid, 0);
        release_bus();
        send_frame(8'h75, 1'b0, 1'b1);
        wait_eval();
        chk("brk_valid", rx_valid, 1);
        chk("brk_data", rx_data, 8'h75);
        chk("brk_ext", rx_ext, 1);
        chk("brk_break", rx_break, 1);
        release_bus();
        drain();
        send_frame(8'h75, 1'b0, 1'b1);
        wait_eval();
        chk("plain_valid", rx_valid, 1);
        chk("plain_data", rx_data, 8'h75);
        chk("plain_ext", rx_ext, 0);
        chk("plain_break", rx_break, 0);
        release_bus();
        drain();
`else
        send_frame(8'hE0, 1'b0, 1'b1);
        wait_eval();
        chk("raw_e0_valid", rx_valid, 1);
        chk("raw_e0_data", rx_data, 8'hE0);
        release_bus();
        drain();
        send_frame(8'hF0, 1'b0, 1'b1);
        wait_eval();
        chk("raw_f0_valid", rx_valid, 1);
        chk("raw_f0_data", rx_data, 8'hF0);
        release_bus();
        drain();
`endif

        // Reset mid-frame aborts silently
        drive_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
        wait_clks(HALF);
        ps2_clk = 1'b1;
        wait_clks(5);
        chk("mid_busy", busy, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_clks(3);
        chk("mid_after_frame_err", frame_err, 0);
        chk("mid_after_valid", rx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
